// File: rtl/ysyx_25040111_utype_dec_queue.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25040111_utype_dec_queue
// Description : U-type (LUI/AUIPC) decode slice for the IDU. Decodes rd, imm
//               and op class from the raw instruction, then queues each
//               decoded micro-op in a DEPTH-entry FIFO with valid/ready on the
//               IFU side and on the EXU side. Non-U-type opcodes are flagged
//               illegal but still queued.
//               Optional feature macro: YSYX_25040111_UTYPE_RESULT_EN
//               (when defined, the rd value is precomputed at push time).
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25040111_utype_dec_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic            out_is_lui,
    output logic            out_wen,
    output logic            out_illeg,
    output logic [XLEN-1:0] out_result
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [6:0]       c_OP_LUI   = 7'b0110111;
    localparam logic [6:0]       c_OP_AUIPC = 7'b0010111;
    localparam logic [CNT_W-1:0] c_FULL     = CNT_W'(DEPTH);

    // Control state
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;

    // Payload storage (not reset)
    logic [4:0]      r_rd_mem    [DEPTH];
    logic [XLEN-1:0] r_imm_mem   [DEPTH];
    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic            r_lui_mem   [DEPTH];
    logic            r_wen_mem   [DEPTH];
    logic            r_illeg_mem [DEPTH];

    // Decode
    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm;
    logic            w_is_lui;
    logic            w_is_auipc;
    logic            w_illeg;
    logic            w_wen;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;

    assign w_opcode   = in_inst[6:0];
    assign w_rd       = in_inst[11:7];
    assign w_is_auipc = (w_opcode == c_OP_AUIPC);
    assign w_illeg    = (w_opcode != c_OP_LUI) && !w_is_auipc;
    assign w_is_lui   = (w_opcode == c_OP_LUI);
    assign w_wen      = !w_illeg && (w_rd != 5'd0);

    // Upper immediate; bit 31 is sign-extended into the upper half for RV64
    generate
        if (XLEN > 32) begin : g_imm_wide
            assign w_imm = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
        end else begin : g_imm_narrow
            assign w_imm = {in_inst[31:12], 12'b0};
        end
    endgenerate

    assign in_ready  = (r_count != c_FULL);
    assign w_valid   = (r_count != '0);
    assign out_valid = w_valid;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = w_valid && out_ready;

    // Control state: reset beats flush; flush drops everything incl. a same-cycle push
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Payload write at the tail on every accepted push
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_rd_mem[r_wptr]    <= w_rd;
            r_imm_mem[r_wptr]   <= w_imm;
            r_pc_mem[r_wptr]    <= in_pc;
            r_lui_mem[r_wptr]   <= w_is_lui;
            r_wen_mem[r_wptr]   <= w_wen;
            r_illeg_mem[r_wptr] <= w_illeg;
        end
    end

    // Head presentation; data ports are forced to zero while empty
    assign out_rd     = w_valid ? r_rd_mem[r_rptr]    : '0;
    assign out_imm    = w_valid ? r_imm_mem[r_rptr]   : '0;
    assign out_pc     = w_valid ? r_pc_mem[r_rptr]    : '0;
    assign out_is_lui = w_valid ? r_lui_mem[r_rptr]   : 1'b0;
    assign out_wen    = w_valid ? r_wen_mem[r_rptr]   : 1'b0;
    assign out_illeg  = w_valid ? r_illeg_mem[r_rptr] : 1'b0;

`ifdef YSYX_25040111_UTYPE_RESULT_EN
    logic [XLEN-1:0] r_res_mem [DEPTH];
    logic [XLEN-1:0] w_result;

    // rd value: imm for LUI, pc+imm for AUIPC, zero for illegal words
    always_comb begin
        w_result = '0;
        if (w_is_lui) begin
            w_result = w_imm;
        end else if (w_is_auipc) begin
            w_result = in_pc + w_imm;
        end
    end

    // Precomputed result stored alongside the rest of the payload
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_res_mem[r_wptr] <= w_result;
        end
    end

    assign out_result = w_valid ? r_res_mem[r_rptr] : '0;
`else
    assign out_result = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040111_utype_dec_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_25040111_utype_dec_queue
// Description : Directed self-checking bench for the U-type decode queue.
//               A 32-bit instance covers handshake/FIFO behaviour; a 64-bit
//               instance covers immediate sign extension and AUIPC result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_25040111_utype_dec_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;

    // 32-bit instance
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic        out_is_lui;
    logic        out_wen;
    logic        out_illeg;
    logic [31:0] out_result;

    // 64-bit instance
    logic        in_valid64;
    logic        in_ready64;
    logic [31:0] in_inst64;
    logic [63:0] in_pc64;
    logic        out_valid64;
    logic        out_ready64;
    logic [4:0]  out_rd64;
    logic [63:0] out_imm64;
    logic [63:0] out_pc64;
    logic        out_is_lui64;
    logic        out_wen64;
    logic        out_illeg64;
    logic [63:0] out_result64;

    int total = 0;
    int bad   = 0;

`ifdef YSYX_25040111_UTYPE_RESULT_EN
    localparam bit c_EN = 1'b1;
`else
    localparam bit c_EN = 1'b0;
`endif

    ysyx_25040111_utype_dec_queue #(.XLEN(32), .DEPTH(2)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_imm(out_imm), .out_pc(out_pc), .out_is_lui(out_is_lui),
        .out_wen(out_wen), .out_illeg(out_illeg), .out_result(out_result)
    );

    ysyx_25040111_utype_dec_queue #(.XLEN(64), .DEPTH(2)) dut64 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_inst(in_inst64), .in_pc(in_pc64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_rd(out_rd64),
        .out_imm(out_imm64), .out_pc(out_pc64), .out_is_lui(out_is_lui64),
        .out_wen(out_wen64), .out_illeg(out_illeg64), .out_result(out_result64)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then settle so outputs are sampled away from it
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_empty(input string tag);
        check({tag, ".valid"},  64'(out_valid),  64'd0);
        check({tag, ".rd"},     64'(out_rd),     64'd0);
        check({tag, ".imm"},    64'(out_imm),    64'd0);
        check({tag, ".pc"},     64'(out_pc),     64'd0);
        check({tag, ".is_lui"}, 64'(out_is_lui), 64'd0);
        check({tag, ".wen"},    64'(out_wen),    64'd0);
        check({tag, ".illeg"},  64'(out_illeg),  64'd0);
        check({tag, ".result"}, 64'(out_result), 64'd0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
        in_valid64 = 1'b0; in_inst64 = '0; in_pc64 = '0; out_ready64 = 1'b0;

        // 1: reset held two cycles
        step(); step();
        reset = 1'b0;
        #1;
        expect_empty("rst");
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.valid64",  64'(out_valid64), 64'd0);
        check("rst.imm64",    out_imm64, 64'd0);

        // 2: LUI x5,0x12345
        in_valid = 1'b1; in_inst = 32'h123452b7; in_pc = 32'h80000000;
        step();
        in_valid = 1'b0;
        check("lui.valid",    64'(out_valid),  64'd1);
        check("lui.rd",       64'(out_rd),     64'd5);
        check("lui.imm",      64'(out_imm),    64'h12345000);
        check("lui.pc",       64'(out_pc),     64'h80000000);
        check("lui.is_lui",   64'(out_is_lui), 64'd1);
        check("lui.wen",      64'(out_wen),    64'd1);
        check("lui.illeg",    64'(out_illeg),  64'd0);
        check("lui.result",   64'(out_result), c_EN ? 64'h12345000 : 64'd0);
        check("lui.in_ready", 64'(in_ready),   64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        expect_empty("lui_pop");

        // 3: AUIPC x1,0xFFFFF on the 64-bit instance
        in_valid64 = 1'b1; in_inst64 = 32'hfffff097; in_pc64 = 64'h80000010;
        step();
        in_valid64 = 1'b0;
        check("auipc.valid",  64'(out_valid64),  64'd1);
        check("auipc.rd",     64'(out_rd64),     64'd1);
        check("auipc.imm",    out_imm64,         64'hFFFFFFFF_FFFFF000);
        check("auipc.pc",     out_pc64,          64'h80000010);
        check("auipc.is_lui", 64'(out_is_lui64), 64'd0);
        check("auipc.wen",    64'(out_wen64),    64'd1);
        check("auipc.illeg",  64'(out_illeg64),  64'd0);
        check("auipc.result", out_result64,      c_EN ? 64'h00000000_7FFFF010 : 64'd0);
        out_ready64 = 1'b1;
        step();
        out_ready64 = 1'b0;
        check("auipc_pop.valid", 64'(out_valid64), 64'd0);

        // 4: three back-to-back pushes into a two-entry queue
        in_valid = 1'b1; in_inst = 32'h000010b7; in_pc = 32'h100;   // LUI x1,1
        step();
        check("bp1.in_ready", 64'(in_ready), 64'd1);
        in_inst = 32'h00002137; in_pc = 32'h104;                    // LUI x2,2
        step();
        check("bp2.in_ready", 64'(in_ready), 64'd0);
        check("bp2.head_rd",  64'(out_rd),   64'd1);
        in_inst = 32'h000031b7; in_pc = 32'h108;                    // LUI x3,3 (held off)
        step();
        check("bp3.in_ready", 64'(in_ready), 64'd0);
        check("bp3.head_rd",  64'(out_rd),   64'd1);
        check("bp3.head_imm", 64'(out_imm),  64'h1000);
        out_ready = 1'b1;                                           // pop A, no push
        step();
        check("bp4.in_ready", 64'(in_ready), 64'd1);
        check("bp4.head_rd",  64'(out_rd),   64'd2);
        check("bp4.head_pc",  64'(out_pc),   64'h104);
        step();                                                     // push C, pop B
        in_valid = 1'b0;
        check("bp5.valid",    64'(out_valid), 64'd1);
        check("bp5.head_rd",  64'(out_rd),    64'd3);
        check("bp5.head_pc",  64'(out_pc),    64'h108);
        check("bp5.in_ready", 64'(in_ready),  64'd1);
        step();                                                     // pop C
        out_ready = 1'b0;
        expect_empty("bp6");

        // 5: flush a full queue while offering a new word
        in_valid = 1'b1; in_inst = 32'h000010b7; in_pc = 32'h200;
        step();
        in_inst = 32'h00002137; in_pc = 32'h204;
        step();
        check("fl.pre_in_ready", 64'(in_ready), 64'd0);
        flush = 1'b1; in_inst = 32'h000031b7; in_pc = 32'h208;
        step();
        flush = 1'b0; in_valid = 1'b0;
        expect_empty("fl");
        check("fl.in_ready", 64'(in_ready), 64'd1);
        step();
        check("fl.still_empty", 64'(out_valid), 64'd0);

        // 6: ADDI (illegal here) then LUI x0,1
        in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h300;
        step();
        in_inst = 32'h00001037; in_pc = 32'h304;
        step();
        in_valid = 1'b0;
        check("ill.valid",  64'(out_valid),  64'd1);
        check("ill.illeg",  64'(out_illeg),  64'd1);
        check("ill.wen",    64'(out_wen),    64'd0);
        check("ill.is_lui", 64'(out_is_lui), 64'd0);
        check("ill.rd",     64'(out_rd),     64'd1);
        check("ill.result", 64'(out_result), 64'd0);
        out_ready = 1'b1;
        step();
        check("x0.illeg",  64'(out_illeg),  64'd0);
        check("x0.wen",    64'(out_wen),    64'd0);
        check("x0.is_lui", 64'(out_is_lui), 64'd1);
        check("x0.rd",     64'(out_rd),     64'd0);
        check("x0.imm",    64'(out_imm),    64'h1000);
        check("x0.result", 64'(out_result), c_EN ? 64'h1000 : 64'd0);
        step();
        out_ready = 1'b0;
        expect_empty("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
